// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, key indices,
// column FSM states and small helpers for one-hot key vectors.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = 16;

  localparam logic [3:0] KEY_0  = 4'd0;
  localparam logic [3:0] KEY_1  = 4'd1;
  localparam logic [3:0] KEY_2  = 4'd2;
  localparam logic [3:0] KEY_3  = 4'd3;
  localparam logic [3:0] KEY_4  = 4'd4;
  localparam logic [3:0] KEY_5  = 4'd5;
  localparam logic [3:0] KEY_6  = 4'd6;
  localparam logic [3:0] KEY_7  = 4'd7;
  localparam logic [3:0] KEY_8  = 4'd8;
  localparam logic [3:0] KEY_9  = 4'd9;
  localparam logic [3:0] KEY_10 = 4'd10;
  localparam logic [3:0] KEY_11 = 4'd11;
  localparam logic [3:0] KEY_12 = 4'd12;
  localparam logic [3:0] KEY_13 = 4'd13;
  localparam logic [3:0] KEY_14 = 4'd14;
  localparam logic [3:0] KEY_15 = 4'd15;

  typedef enum logic [1:0] {COL_0, COL_1, COL_2, COL_3} col_state_e;

  // OR of the indices of all set bits; exact when the input is one-hot.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = KEY_0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-key frame debouncer: a key's stable state flips only after
// DEBOUNCE_FRAMES consecutive frames disagreeing with it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] raw_i,
  input  logic                frame_tick_i,
  output logic [NUM_KEYS-1:0] stable_o
);

  localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [CW-1:0] cnt_q, cnt_d;
      logic          stable_q, stable_d;

      // Flipping on the last count clears the counter, so it never wraps.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (frame_tick_i) begin
          if (raw_i[gi] == stable_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = ~stable_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

      assign stable_o[gi] = stable_q;
    end
  endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: column scan, debounce, single-key qualification.
// Optional auto-repeat of key_valid is built when KEY_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV            = 100_000,
  parameter int DEBOUNCE_FRAMES     = 5,
  parameter int REPEAT_DELAY_FRAMES = 125,
  parameter int REPEAT_RATE_FRAMES  = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [NUM_KEYS-1:0] key_status,
  output logic [3:0]          key_code,
  output logic                key_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  col_state_e          col_q, col_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic                sample;
  logic                frame_tick_q, status_tick_q;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] qual_status;
  logic                new_press;
  logic                rep_pulse;
  logic [NUM_KEYS-1:0] key_status_q, key_status_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    col_d     = col_q;
    raw_d     = raw_q;
    sample    = 1'b0;
    col       = 4'b1110;
    case (col_q)
      COL_0: col = 4'b1110;
      COL_1: col = 4'b1101;
      COL_2: col = 4'b1011;
      COL_3: col = 4'b0111;
      default: col = 4'b1110;
    endcase
    if (div_cnt_q == DIV_LAST) begin
      sample    = 1'b1;
      div_cnt_d = '0;
      case (col_q)
        COL_0: begin col_d = COL_1; raw_d[3:0]   = ~row; end
        COL_1: begin col_d = COL_2; raw_d[7:4]   = ~row; end
        COL_2: begin col_d = COL_3; raw_d[11:8]  = ~row; end
        COL_3: begin col_d = COL_0; raw_d[15:12] = ~row; end
        default: col_d = COL_0;
      endcase
    end
  end

  // frame_tick_q follows the col-3 sample so the debouncer sees a complete
  // frame; status_tick_q follows once more so qualification sees new stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      col_q         <= COL_0;
      raw_q         <= '0;
      frame_tick_q  <= 1'b0;
      status_tick_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      col_q         <= col_d;
      raw_q         <= raw_d;
      frame_tick_q  <= sample && (col_q == COL_3);
      status_tick_q <= frame_tick_q;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .raw_i       (raw_q),
    .frame_tick_i(frame_tick_q),
    .stable_o    (stable)
  );

  assign qual_status = (popcount16(stable) == 5'd1) ? stable : '0;
  assign new_press   = status_tick_q && (qual_status != '0) && (qual_status != key_status_q);

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                        REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;

  // rep_armed_q marks that the initial delay has elapsed and the rate applies.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_pulse   = 1'b0;
    if (status_tick_q) begin
      if ((qual_status != key_status_q) || (key_status_q == '0)) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end else if (!rep_armed_q) begin
        if (rep_cnt_q == RW'(REPEAT_DELAY_FRAMES - 1)) begin
          rep_pulse   = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else if (rep_cnt_q == RW'(REPEAT_RATE_FRAMES - 1)) begin
        rep_pulse = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY_FRAMES), 32'(REPEAT_RATE_FRAMES)};
  assign rep_pulse = 1'b0;
`endif

  always_comb begin
    key_status_d = key_status_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    if (status_tick_q) begin
      key_status_d = qual_status;
      if (new_press || rep_pulse) begin
        key_valid_d = 1'b1;
        key_code_d  = onehot_to_idx(qual_status);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_status_q <= '0;
      key_code_q   <= KEY_0;
      key_valid_q  <= 1'b0;
    end else begin
      key_status_q <= key_status_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign key_status = key_status_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a small scan divider; the keypad
// is modelled as a switch matrix driven by the 'pressed' key vector.
module tb_keypad_scanner;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_status;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] pressed;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] status;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV           (4),
    .DEBOUNCE_FRAMES    (3),
    .REPEAT_DELAY_FRAMES(4),
    .REPEAT_RATE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_status(key_status),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && (col[k/4] == 1'b0)) row[k%4] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input logic [15:0] status);
    exp_t e;
    e.code   = code;
    e.status = status;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic align_frame(input string name);
    int n;
    n = 0;
    while (col != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check(name, {28'd0, col}, 32'he);
  endtask

  // Monitor: every key_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got key_code=%0d key_status=0x%h, expected no pulse",
                 key_code, key_status);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
        check("pulse_status", {16'd0, key_status}, {16'd0, e.status});
      end
    end
  end

  initial begin
    logic [3:0] exp_col;
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);

    // 1: reset state and column rotation
    check("rst_col", {28'd0, col}, 32'he);
    check("rst_status", {16'd0, key_status}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      if (i % 2 == 0) check("col_seq", {28'd0, col}, {28'd0, exp_col});
      @(negedge clk);
    end

    // 2: hold key 5 -> accepted once, then release
    pressed = 16'h0020;
    push_exp(4'd5, 16'h0020);
    wait_drain(6 * FRAME, "t2_accept");
    check("t2_status", {16'd0, key_status}, 32'h0020);
    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("t2_release", {16'd0, key_status}, 32'd0);
    check("t2_code_held", {28'd0, key_code}, 32'd5);

    // 3: key 5 bouncing every frame never becomes stable
    for (int i = 0; i < 8; i++) begin
      pressed = pressed ^ 16'h0020;
      repeat (FRAME) @(negedge clk);
      check("t3_bounce", {16'd0, key_status}, 32'd0);
    end
    repeat (4 * FRAME) @(negedge clk);

    // 4: two keys qualify to zero; releasing one yields a fresh press
    align_frame("t4_align");
    pressed = 16'h8001;
    repeat (6 * FRAME) @(negedge clk);
    check("t4_multi", {16'd0, key_status}, 32'd0);
    pressed = 16'h0001;
    push_exp(4'd0, 16'h0001);
    wait_drain(6 * FRAME, "t4_accept");
    check("t4_status", {16'd0, key_status}, 32'h0001);
    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("t4_release", {16'd0, key_status}, 32'd0);

    // 5: reset during a held key, key reappears after debounce
    pressed = 16'h0400;
    push_exp(4'd10, 16'h0400);
    wait_drain(6 * FRAME, "t5_accept");
    check("t5_status", {16'd0, key_status}, 32'h0400);
    rst = 1'b1;
    #1;
    check("t5_rst_status", {16'd0, key_status}, 32'd0);
    check("t5_rst_code", {28'd0, key_code}, 32'd0);
    check("t5_rst_col", {28'd0, col}, 32'he);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(4'd10, 16'h0400);
    wait_drain(6 * FRAME, "t5_reaccept");
    check("t5_status2", {16'd0, key_status}, 32'h0400);
    pressed = '0;
    repeat (5 * FRAME) @(negedge clk);
    check("t5_release", {16'd0, key_status}, 32'd0);

    // 6: long hold of key 3
    pressed = 16'h0008;
    push_exp(4'd3, 16'h0008);
`ifdef KEY_REPEAT_EN
    repeat (4) push_exp(4'd3, 16'h0008);
`endif
    wait_drain(20 * FRAME, "t6_pulses");
`ifdef KEY_REPEAT_EN
    // Release takes 3 frames to debounce, so one more rate pulse lands first.
    push_exp(4'd3, 16'h0008);
`else
    repeat (12 * FRAME) @(negedge clk);
`endif
    check("t6_status", {16'd0, key_status}, 32'h0008);
    pressed = '0;
    wait_drain(6 * FRAME, "t6_release_drain");
    repeat (5 * FRAME) @(negedge clk);
    check("t6_release", {16'd0, key_status}, 32'd0);
    check("t6_code_held", {28'd0, key_code}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
